// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Registered shift execute stage of the 64-bit ALU datapath. An operand pair
// and shift opcode are accepted from issue, the op goes through an operand
// latch (S1) and a result latch (S2), and the result is presented to
// writeback. Both sides use valid/ready handshakes with full backpressure.
// Throughput is one op per cycle. Latency is two cycles when not stalled.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   flush                synchronous kill of every in-flight op
//   in_valid / in_ready  issue handshake (in_ready is combinational via out_ready)
//   in_op                00=SRL 01=SLL 10=SRA 11=PASS(a)
//   in_a, in_b, in_tag   value, shift amount (only in_b[5:0] used), dest tag
//   out_valid/out_ready  writeback handshake
//   out_y, out_zero      result and (result == 0)
//   out_carry, out_tag   last bit shifted out, tag carried through
// -----------------------------------------------------------------------------
module shift_exec_stage #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_y,
   output logic             out_zero,
   output logic             out_carry,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W = 6;

   // S1 operand latch
   logic             s1_valid_r;
   logic [1:0]       s1_op_r;
   logic [XLEN-1:0]  s1_a_r;
   logic [SH_W-1:0]  s1_sh_r;
   logic [TAG_W-1:0] s1_tag_r;

   // S2 result latch
   logic             out_valid_r;
   logic [XLEN-1:0]  out_y_r;
   logic             out_zero_r;
   logic             out_carry_r;
   logic [TAG_W-1:0] out_tag_r;

   logic             s1_adv_s;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [XLEN:0]    ext_s;
   logic [XLEN-1:0]  y_s;
   logic             carry_s;
   logic             zero_s;
   logic             unused_b_s;

   // Right log-shifter on a value extended by one guard bit below bit 0.
   // After shifting, the guard bit holds the last bit shifted out.
   function automatic logic [XLEN:0] shr_ext(input logic [XLEN:0] v,
                                             input logic [SH_W-1:0] sh,
                                             input logic fill);
      logic [XLEN:0] t;
      t = v;
      t = sh[0] ? {fill,        t[XLEN:1]}  : t;
      t = sh[1] ? {{2{fill}},   t[XLEN:2]}  : t;
      t = sh[2] ? {{4{fill}},   t[XLEN:4]}  : t;
      t = sh[3] ? {{8{fill}},   t[XLEN:8]}  : t;
      t = sh[4] ? {{16{fill}},  t[XLEN:16]} : t;
      t = sh[5] ? {{32{fill}},  t[XLEN:32]} : t;
      return t;
   endfunction

   // Left log-shifter on a value extended by one guard bit above the MSB.
   // After shifting, the guard bit holds the last bit shifted out.
   function automatic logic [XLEN:0] shl_ext(input logic [XLEN:0] v,
                                             input logic [SH_W-1:0] sh);
      logic [XLEN:0] t;
      t = v;
      t = sh[0] ? {t[XLEN-1:0],  1'b0}      : t;
      t = sh[1] ? {t[XLEN-2:0],  2'b0}      : t;
      t = sh[2] ? {t[XLEN-4:0],  4'b0}      : t;
      t = sh[3] ? {t[XLEN-8:0],  8'b0}      : t;
      t = sh[4] ? {t[XLEN-16:0], 16'b0}     : t;
      t = sh[5] ? {t[XLEN-32:0], 32'b0}     : t;
      return t;
   endfunction

   // Only the low six bits of the amount matter. The upper bits are folded
   // into a sink so they stay visibly ignored.
   assign unused_b_s = ^in_b[XLEN-1:SH_W];

   assign s1_adv_s   = s1_valid_r & (~out_valid_r | out_ready);
   assign in_ready   = ~s1_valid_r | s1_adv_s;
   assign in_xfer_s  = in_valid & in_ready;
   assign out_xfer_s = out_valid_r & out_ready;

   // Shift datapath: compute result and carry-out from the S1 contents.
   always_comb begin
      ext_s   = {(XLEN+1){1'b0}};
      y_s     = {XLEN{1'b0}};
      carry_s = 1'b0;
      case (s1_op_r)
         2'b00: begin
            ext_s   = shr_ext({s1_a_r, 1'b0}, s1_sh_r, 1'b0);
            y_s     = ext_s[XLEN:1];
            carry_s = ext_s[0];
         end
         2'b01: begin
            ext_s   = shl_ext({1'b0, s1_a_r}, s1_sh_r);
            y_s     = ext_s[XLEN-1:0];
            carry_s = ext_s[XLEN];
         end
         2'b10: begin
            ext_s   = shr_ext({s1_a_r, 1'b0}, s1_sh_r, s1_a_r[XLEN-1]);
            y_s     = ext_s[XLEN:1];
            carry_s = ext_s[0];
         end
         2'b11: begin
            y_s     = s1_a_r;
            carry_s = 1'b0;
         end
         default: begin
            y_s     = s1_a_r;
            carry_s = 1'b0;
         end
      endcase
      zero_s = (y_s == {XLEN{1'b0}});
   end

   // S1 operand latch: flush beats any transfer, and a new op may enter in
   // the same cycle that the held op advances into S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= 2'b00;
         s1_a_r     <= {XLEN{1'b0}};
         s1_sh_r    <= {SH_W{1'b0}};
         s1_tag_r   <= {TAG_W{1'b0}};
      end else begin
         if (flush) begin
            s1_valid_r <= 1'b0;
         end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
         end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
         end else begin
            s1_valid_r <= s1_valid_r;
         end
         if (in_xfer_s && !flush) begin
            s1_op_r  <= in_op;
            s1_a_r   <= in_a;
            s1_sh_r  <= in_b[SH_W-1:0];
            s1_tag_r <= in_tag;
         end
      end
   end

   // S2 result latch: reloads on advance (even while draining), otherwise
   // clears valid on an output transfer. The data holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_y_r     <= {XLEN{1'b0}};
         out_zero_r  <= 1'b0;
         out_carry_r <= 1'b0;
         out_tag_r   <= {TAG_W{1'b0}};
      end else begin
         if (flush) begin
            out_valid_r <= 1'b0;
         end else if (s1_adv_s) begin
            out_valid_r <= 1'b1;
         end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
         if (s1_adv_s && !flush) begin
            out_y_r     <= y_s;
            out_zero_r  <= zero_s;
            out_carry_r <= carry_s;
            out_tag_r   <= s1_tag_r;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_y     = out_y_r;
   assign out_zero  = out_zero_r;
   assign out_carry = out_carry_r;
   assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_y;
   logic        out_zero;
   logic        out_carry;
   logic [4:0]  out_tag;

   shift_exec_stage #(.XLEN(64), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_zero(out_zero), .out_carry(out_carry), .out_tag(out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  tag;
      logic [63:0] y;
      logic        zero;
      logic        carry;
   } vec_t;

   typedef struct {
      logic [63:0] y;
      logic        zero;
      logic        carry;
      logic [4:0]  tag;
   } exp_t;

   vec_t vt[13];
   exp_t sbq[$];
   exp_t cur_exp;
   exp_t mon_e;
   exp_t ea;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference shifter built from the language operators
   function automatic exp_t mk(input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] tag);
      exp_t r;
      int   sh;
      sh      = int'(b[5:0]);
      r.tag   = tag;
      r.carry = 1'b0;
      case (op)
         2'b00: begin r.y = a >> sh; if (sh != 0) r.carry = a[sh-1]; end
         2'b01: begin r.y = a << sh; if (sh != 0) r.carry = a[64-sh]; end
         2'b10: begin r.y = 64'($signed(a) >>> sh); if (sh != 0) r.carry = a[sh-1]; end
         default: r.y = a;
      endcase
      r.zero = (r.y == 64'd0);
      return r;
   endfunction

   task automatic present(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, input exp_t e);
      in_op = op; in_a = a; in_b = b; in_tag = tag;
      cur_exp = e;
      in_valid = 1'b1;
   endtask

   task automatic complete(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      if (done) begin
         @(posedge clk); #1;
      end else begin
         total++; bad++;
         $display("FAIL accept_timeout_%s actual=in_ready_low required=accepted", name);
      end
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input string name);
      present(op, a, b, tag, mk(op, a, b, tag));
      complete(name);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
      chk({"drain_", name}, 64'(sbq.size()), 64'd0);
   endtask

   // scoreboard: pop on output transfer, push on input transfer
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_out actual=tag%0d required=no_output", out_tag);
            end else begin
               mon_e = sbq.pop_front();
               chk($sformatf("y_tag%0d", mon_e.tag), out_y, mon_e.y);
               chk($sformatf("zero_tag%0d", mon_e.tag), 64'(out_zero), 64'(mon_e.zero));
               chk($sformatf("carry_tag%0d", mon_e.tag), 64'(out_carry), 64'(mon_e.carry));
               chk($sformatf("tag_tag%0d", mon_e.tag), 64'(out_tag), 64'(mon_e.tag));
            end
         end
         if (flush) sbq.delete();
         else if (in_valid && in_ready) sbq.push_back(cur_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{2'b00, 64'h8000_0000_0000_0001, 64'd1,  5'd1,  64'h4000_0000_0000_0000, 1'b0, 1'b1};
      vt[1]  = '{2'b10, 64'hF000_0000_0000_0000, 64'h44, 5'd2,  64'hFF00_0000_0000_0000, 1'b0, 1'b0};
      vt[2]  = '{2'b01, 64'h1,                   64'd63, 5'd3,  64'h8000_0000_0000_0000, 1'b0, 1'b0};
      vt[3]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd1,  5'd4,  64'h0,                   1'b1, 1'b1};
      vt[4]  = '{2'b11, 64'h1234_5678_9ABC_DEF0, 64'd5,  5'd5,  64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
      vt[5]  = '{2'b10, 64'h8000_0000_0000_0000, 64'd63, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vt[6]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 5'd7,  64'h1,                   1'b0, 1'b1};
      vt[7]  = '{2'b00, 64'hFF,                  64'd0,  5'd8,  64'hFF,                  1'b0, 1'b0};
      vt[8]  = '{2'b10, 64'h7000_0000_0000_0000, 64'd60, 5'd9,  64'h7,                   1'b0, 1'b0};
      vt[9]  = '{2'b01, 64'h7,                   64'd62, 5'd10, 64'hC000_0000_0000_0000, 1'b0, 1'b1};
      vt[10] = '{2'b00, 64'h10,                  64'd5,  5'd11, 64'h0,                   1'b1, 1'b1};
      vt[11] = '{2'b01, 64'hA5, 64'hFFFF_FFFF_FFFF_FFC4, 5'd12, 64'hA50,                 1'b0, 1'b0};
      vt[12] = '{2'b00, 64'h0123_4567_89AB_CDEF, 64'd8,  5'd13, 64'h0001_2345_6789_ABCD, 1'b0, 1'b1};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
      in_a = 64'd0; in_b = 64'd0; in_tag = 5'd0; out_ready = 1'b1;
      cur_exp = '{64'd0, 1'b0, 1'b0, 5'd0};

      // reset state
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_y",     out_y,          64'd0);
      chk("rst_out_zero",  64'(out_zero),  64'd0);
      chk("rst_out_carry", 64'(out_carry), 64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // first op: two-cycle latency
      present(vt[0].op, vt[0].a, vt[0].b, vt[0].tag, '{vt[0].y, vt[0].zero, vt[0].carry, vt[0].tag});
      complete("lat");
      @(negedge clk);
      chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
      drain("lat");

      // table: back-to-back stream
      @(posedge clk); #1;
      for (int i = 1; i < 13; i++) begin
         present(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, '{vt[i].y, vt[i].zero, vt[i].carry, vt[i].tag});
         complete($sformatf("vec%0d", i));
      end
      drain("table");

      // backpressure: two accepted, third stalls, outputs stable
      @(posedge clk); #1;
      out_ready = 1'b0;
      ea = mk(2'b00, 64'hDEAD_BEEF_0000_1111, 64'd4, 5'd20);
      send(2'b00, 64'hDEAD_BEEF_0000_1111, 64'd4, 5'd20, "bp_a");
      send(2'b01, 64'h0000_0000_F0F0_F0F0, 64'd12, 5'd21, "bp_b");
      present(2'b10, 64'h8888_0000_0000_0001, 64'd33, 5'd22, mk(2'b10, 64'h8888_0000_0000_0001, 64'd33, 5'd22));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready",  64'(in_ready),  64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_out_y",     out_y,          ea.y);
         chk("bp_out_tag",   64'(out_tag),   64'd20);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      complete("bp_c");
      send(2'b11, 64'h5555_AAAA_5555_AAAA, 64'd7, 5'd23, "bp_d");
      drain("bp");

      // flush with S1 and S2 both occupied
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(2'b00, 64'hFFFF_0000_FFFF_0000, 64'd16, 5'd24, "fl_a");
      send(2'b01, 64'h3,                   64'd2,  5'd25, "fl_b");
      present(2'b00, 64'h1, 64'd0, 5'd30, mk(2'b00, 64'h1, 64'd0, 5'd30));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_in_ready",  64'(in_ready),  64'd1);
      repeat (3) @(negedge clk);
      chk("fl_no_ghost",  64'(out_valid), 64'd0);
      @(posedge clk); #1;
      send(2'b10, 64'h8000_0000_0000_00FF, 64'd8, 5'd26, "fl_after");
      drain("fl");

      // flush on an empty pipe discards the op offered that cycle
      @(posedge clk); #1;
      present(2'b11, 64'h77, 64'd0, 5'd31, mk(2'b11, 64'h77, 64'd0, 5'd31));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("fl_empty_discard", 64'(out_valid), 64'd0);

      // asynchronous reset between edges
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(2'b00, 64'h3,  64'd1, 5'd27, "rs_a");
      send(2'b00, 64'h30, 64'd4, 5'd28, "rs_b");
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_y",     out_y,          64'd0);
      chk("arst_out_carry", 64'(out_carry), 64'd0);
      chk("arst_out_tag",   64'(out_tag),   64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send(2'b00, 64'hFF, 64'd0, 5'd29, "rs_after");
      drain("rs");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
